// File: rtl/gcn_mem_pkg.sv
// gcn_mem_pkg: shared definitions for the GCN matrix memory.
//   - loader_state_e : loader FSM state encoding (idle / load / done)
//   - FEATURE_BASE   : first read address of the feature matrix
//   - row_t          : one read row (ROW_ELEMS x ELEM_WIDTH) at the default geometry
//   - idx_width/umax : index-width helpers (width never below 1 bit)
package gcn_mem_pkg;

    localparam int unsigned FEATURE_BASE = 512;
    localparam int unsigned ROW_ELEMS    = 96;
    localparam int unsigned ELEM_WIDTH   = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } loader_state_e;

    typedef logic [ELEM_WIDTH-1:0] row_t [ROW_ELEMS];

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gcn_mem_loader.sv
// gcn_mem_loader: loader FSM and row/column counters for streaming a matrix into storage.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_start_i          begins a load (honoured only in idle)
//   load_sel_i            0 = weight matrix, 1 = feature matrix (sampled with load_start_i)
//   load_valid_i          element available this cycle
//   load_ready_o          high only while loading
//   load_done_o           high for the single cycle after the last element is accepted
//   wr_en_o, wr_sel_o     write strobe and target matrix
//   wr_row_o, wr_col_o    element position being written
module gcn_mem_loader
    import gcn_mem_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS = 6,
    parameter int unsigned FEATURE_COLS = 96,
    parameter int unsigned WEIGHT_COLS  = 3,
    parameter int unsigned WEIGHT_ROWS  = 96,
    parameter int unsigned ROW_W        = 3,
    parameter int unsigned COL_W        = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_start_i,
    input  logic             load_sel_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             load_done_o,
    output logic             wr_en_o,
    output logic             wr_sel_o,
    output logic [ROW_W-1:0] wr_row_o,
    output logic [COL_W-1:0] wr_col_o
);

    loader_state_e    state_q, state_d;
    logic             sel_q, sel_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] last_row;
    logic [COL_W-1:0] last_col;

    // Weight rows are WEIGHT_ROWS long and there are WEIGHT_COLS of them (transposed storage).
    assign last_col = sel_q ? COL_W'(FEATURE_COLS - 1) : COL_W'(WEIGHT_ROWS - 1);
    assign last_row = sel_q ? ROW_W'(FEATURE_ROWS - 1) : ROW_W'(WEIGHT_COLS - 1);

    assign load_ready_o = (state_q == StLoad);
    assign load_done_o  = (state_q == StDone);
    // Reset wins over a pending element so nothing is written on the reset edge.
    assign wr_en_o      = load_ready_o && load_valid_i && !rst_i;
    assign wr_sel_o     = sel_q;
    assign wr_row_o     = row_q;
    assign wr_col_o     = col_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            StIdle: begin
                if (load_start_i) begin
                    state_d = StLoad;
                    sel_d   = load_sel_i;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StLoad: begin
                if (load_valid_i) begin
                    if (col_q == last_col) begin
                        col_d = '0;
                        if (row_q == last_row) begin
                            row_d   = '0;
                            state_d = StDone;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: rtl/gcn_matrix_memory.sv
// gcn_matrix_memory: weight/feature matrix storage with a streaming loader and a
// one-cycle-latency row read port.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   load_start/load_sel             start a load of weight (0) or feature (1) matrix
//   load_valid/load_data/load_ready element handshake, row-major
//   load_done                       one-cycle pulse after the last element is written
//   enable_read/read_address        row read request (weights at 0.., features at FEATURE_BASE..)
//   data_out/data_valid/addr_error  registered response to the previous cycle's request
// Build option: GCN_MEM_WR_BYPASS_EN forwards a same-cycle write into the read row;
// without it a same-cycle read returns the pre-write contents.
module gcn_matrix_memory
    import gcn_mem_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS  = 6,
    parameter int unsigned FEATURE_COLS  = 96,
    parameter int unsigned WEIGHT_COLS   = 3,
    parameter int unsigned WEIGHT_ROWS   = 96,
    parameter int unsigned DATA_WIDTH    = 5,
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned FEATURE_BASE  = gcn_mem_pkg::FEATURE_BASE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic                     load_sel,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic                     load_ready,
    output logic                     load_done,
    input  logic                     enable_read,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    data_out [WEIGHT_ROWS],
    output logic                     data_valid,
    output logic                     addr_error
);

    localparam int unsigned WIDX_W = idx_width(WEIGHT_COLS);
    localparam int unsigned FIDX_W = idx_width(FEATURE_ROWS);
    localparam int unsigned OCOL_W = idx_width(WEIGHT_ROWS);
    localparam int unsigned FCOL_W = idx_width(FEATURE_COLS);
    localparam int unsigned ROW_W  = idx_width(umax(WEIGHT_COLS, FEATURE_ROWS));
    localparam int unsigned COL_W  = idx_width(umax(WEIGHT_ROWS, FEATURE_COLS));

    logic             wr_en;
    logic             wr_sel;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;

    logic [DATA_WIDTH-1:0] weight_mem  [WEIGHT_COLS][WEIGHT_ROWS];
    logic [DATA_WIDTH-1:0] feature_mem [FEATURE_ROWS][FEATURE_COLS];

    logic [DATA_WIDTH-1:0] data_out_q [WEIGHT_ROWS];
    logic [DATA_WIDTH-1:0] data_out_d [WEIGHT_ROWS];
    logic                  data_valid_q, data_valid_d;
    logic                  addr_error_q, addr_error_d;

    logic [31:0]       addr_ext;
    logic [31:0]       fidx_full;
    logic              is_weight;
    logic              is_feature;
    logic [WIDX_W-1:0] widx;
    logic [FIDX_W-1:0] fidx;

    gcn_mem_loader #(
        .FEATURE_ROWS (FEATURE_ROWS),
        .FEATURE_COLS (FEATURE_COLS),
        .WEIGHT_COLS  (WEIGHT_COLS),
        .WEIGHT_ROWS  (WEIGHT_ROWS),
        .ROW_W        (ROW_W),
        .COL_W        (COL_W)
    ) u_loader (
        .clk_i        (clk),
        .rst_i        (reset),
        .load_start_i (load_start),
        .load_sel_i   (load_sel),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_done_o  (load_done),
        .wr_en_o      (wr_en),
        .wr_sel_o     (wr_sel),
        .wr_row_o     (wr_row),
        .wr_col_o     (wr_col)
    );

    // Storage has no reset: an aborted load keeps whatever was already written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) begin
                feature_mem[wr_row[FIDX_W-1:0]][wr_col[FCOL_W-1:0]] <= load_data;
            end else begin
                weight_mem[wr_row[WIDX_W-1:0]][wr_col[OCOL_W-1:0]] <= load_data;
            end
        end
    end

    assign addr_ext   = 32'(read_address);
    assign fidx_full  = addr_ext - 32'(FEATURE_BASE);
    assign is_weight  = addr_ext < 32'(WEIGHT_COLS);
    assign is_feature = (addr_ext >= 32'(FEATURE_BASE)) &&
                        (addr_ext < 32'(FEATURE_BASE + FEATURE_ROWS));
    assign widx       = addr_ext[WIDX_W-1:0];
    assign fidx       = fidx_full[FIDX_W-1:0];

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        addr_error_d = 1'b0;
        if (enable_read) begin
            data_valid_d = 1'b1;
            if (is_weight) begin
                data_out_d = weight_mem[widx];
`ifdef GCN_MEM_WR_BYPASS_EN
                if (wr_en && !wr_sel && (wr_row[WIDX_W-1:0] == widx)) begin
                    data_out_d[wr_col[OCOL_W-1:0]] = load_data;
                end
`endif
            end else if (is_feature) begin
                for (int unsigned k = 0; k < WEIGHT_ROWS; k++) begin
                    data_out_d[k] = (k < FEATURE_COLS) ? feature_mem[fidx][FCOL_W'(k)] : '0;
                end
`ifdef GCN_MEM_WR_BYPASS_EN
                if (wr_en && wr_sel && (wr_row[FIDX_W-1:0] == fidx)) begin
                    data_out_d[wr_col[OCOL_W-1:0]] = load_data;
                end
`endif
            end else begin
                for (int unsigned k = 0; k < WEIGHT_ROWS; k++) begin
                    data_out_d[k] = '0;
                end
                addr_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '{default: '0};
            data_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            addr_error_q <= addr_error_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign addr_error = addr_error_q;

endmodule

// File: tb/tb_gcn_matrix_memory.sv
// Testbench for gcn_matrix_memory: directed loads and reads; read responses are
// queued as expectations and checked by a monitor whenever data_valid is high.
module tb_gcn_matrix_memory;

    localparam int NE = 96;
    localparam int DW = 5;
    localparam int RB = NE * DW;

    localparam int MODE_W  = 0;  // weight element e -> e mod 32
    localparam int MODE_F  = 1;  // feature element -> its row index
    localparam int MODE_F2 = 2;  // feature element -> 10 + row index

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic          load_sel;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    logic          enable_read;
    logic [12:0]   read_address;
    logic [DW-1:0] data_out [NE];
    logic          data_valid;
    logic          addr_error;

    int n_vec  = 0;
    int n_miss = 0;

    logic [RB-1:0] exp_data_q [$];
    logic          exp_err_q  [$];
    string         exp_name_q [$];

    gcn_matrix_memory dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_sel     (load_sel),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .load_done    (load_done),
        .enable_read  (enable_read),
        .read_address (read_address),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .addr_error   (addr_error)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] elem(input int mode, input int e);
        int v;
        if (mode == MODE_W)      v = e % 32;
        else if (mode == MODE_F) v = e / NE;
        else                     v = 10 + e / NE;
        return DW'(v);
    endfunction

    function automatic logic [RB-1:0] mk_row(input int mode, input int r);
        logic [RB-1:0] row;
        for (int k = 0; k < NE; k++) row[k*DW +: DW] = elem(mode, r * NE + k);
        return row;
    endfunction

    function automatic logic [RB-1:0] pack_out();
        logic [RB-1:0] row;
        for (int k = 0; k < NE; k++) row[k*DW +: DW] = data_out[k];
        return row;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one read; the response is checked by the monitor.
    task automatic rd(input logic [12:0] addr, input logic [RB-1:0] exp, input logic err,
                      input string nm);
        enable_read  = 1'b1;
        read_address = addr;
        exp_data_q.push_back(exp);
        exp_err_q.push_back(err);
        exp_name_q.push_back(nm);
        tick();
        enable_read = 1'b0;
    endtask

    // Monitor: every data_valid cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_valid: got data_valid=1 expected 0");
            end else begin
                logic [RB-1:0] ed;
                logic          ee;
                string         nm;
                ed = exp_data_q.pop_front();
                ee = exp_err_q.pop_front();
                nm = exp_name_q.pop_front();
                n_vec++;
                if (pack_out() !== ed || addr_error !== ee) begin
                    n_miss++;
                    $display("FAIL %s: got err=%0b data=%0h expected err=%0b data=%0h",
                             nm, addr_error, pack_out(), ee, ed);
                end
            end
        end
    end

    // Stream `total` elements; optional gaps on load_valid, a stray load_start after
    // `glitch_at` accepted elements, or a reset abort after `abort_at` accepted elements.
    task automatic do_load(input logic sel, input int mode, input int total, input bit gaps,
                           input int glitch_at, input int abort_at);
        int accepted = 0;
        int cyc      = 0;
        int stop_at  = (abort_at >= 0) ? abort_at : total;
        bit early    = 1'b0;
        bit glitched = 1'b0;
        bit take;
        load_sel   = sel;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ready_in_load", load_ready, 1);
        while (accepted < stop_at && cyc < 2000) begin
            load_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            load_data  = elem(mode, accepted);
            load_start = (glitch_at >= 0) && !glitched && (accepted == glitch_at);
            load_sel   = load_start ? ~sel : sel;
            if (load_start) glitched = 1'b1;
            take = load_valid && load_ready;
            tick();
            cyc++;
            if (take) accepted++;
            if (load_done && accepted < total) early = 1'b1;
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        load_sel   = sel;
        if (cyc >= 2000) begin
            chk("load_timeout", 1, 0);
        end else if (abort_at >= 0) begin
            // Abort: reset asserted together with a start and a read, reset must win.
            reset        = 1'b1;
            load_start   = 1'b1;
            enable_read  = 1'b1;
            read_address = 13'd512;
            tick();
            reset       = 1'b0;
            load_start  = 1'b0;
            enable_read = 1'b0;
            chk("abort_ready", load_ready, 0);
            chk("abort_done", load_done, 0);
            chk("abort_valid", data_valid, 0);
            chk("abort_dout", pack_out(), '0);
            tick();
            chk("abort_idle", load_ready, 0);
        end else begin
            chk("no_early_done", early, 0);
            chk("done_pulse", load_done, 1);
            chk("ready_at_done", load_ready, 0);
            tick();
            chk("done_single", load_done, 0);
        end
    endtask

    initial begin
        logic [RB-1:0] exp_row;

        reset        = 1'b1;
        load_start   = 1'b0;
        load_sel     = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        enable_read  = 1'b0;
        read_address = '0;
        tick();
        tick();
        chk("rst_ready", load_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_err", addr_error, 0);
        chk("rst_dout", pack_out(), '0);
        reset = 1'b0;
        tick();

        // Weight load with load_valid on every other cycle and a stray load_start.
        do_load(1'b0, MODE_W, 3 * NE, 1'b1, 50, -1);
        rd(13'd1, mk_row(MODE_W, 1), 1'b0, "w_row1");
        rd(13'd0, mk_row(MODE_W, 0), 1'b0, "w_row0");
        rd(13'd2, mk_row(MODE_W, 2), 1'b0, "w_row2");
        rd(13'd3, '0, 1'b1, "w_unmapped3");

        // Feature load, element = row index.
        do_load(1'b1, MODE_F, 6 * NE, 1'b0, -1, -1);
        rd(13'd517, mk_row(MODE_F, 5), 1'b0, "f_row5");
        tick();
        chk("hold_dout", pack_out(), mk_row(MODE_F, 5));
        chk("hold_valid", data_valid, 0);
        chk("hold_err", addr_error, 0);
        rd(13'd518, '0, 1'b1, "f_unmapped518");
        tick();
        chk("err_clears", addr_error, 0);
        rd(13'd512, mk_row(MODE_F, 0), 1'b0, "f_row0");
        rd(13'd511, '0, 1'b1, "f_unmapped511");
        rd(13'd8191, '0, 1'b1, "f_unmapped8191");
        rd(13'd514, mk_row(MODE_F, 2), 1'b0, "f_row2");

        // Reset after 100 new feature elements: row 0 new, row 1 partly new.
        do_load(1'b1, MODE_F2, 6 * NE, 1'b0, -1, 100);
        rd(13'd512, mk_row(MODE_F2, 0), 1'b0, "abort_row0");
        exp_row = mk_row(MODE_F, 1);
        for (int k = 0; k < 4; k++) exp_row[k*DW +: DW] = 5'd11;
        rd(13'd513, exp_row, 1'b0, "abort_row1");
        rd(13'd517, mk_row(MODE_F, 5), 1'b0, "abort_row5");

        // Same-cycle write of weight row 0 element 0 and read of address 0.
        load_sel   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        exp_row    = mk_row(MODE_W, 0);
`ifdef GCN_MEM_WR_BYPASS_EN
        exp_row[0 +: DW] = 5'd7;
`endif
        load_valid = 1'b1;
        load_data  = 5'd7;
        rd(13'd0, exp_row, 1'b0, "wr_rd_same_cycle");
        load_valid = 1'b0;
        reset      = 1'b1;
        tick();
        reset   = 1'b0;
        exp_row = mk_row(MODE_W, 0);
        exp_row[0 +: DW] = 5'd7;
        rd(13'd0, exp_row, 1'b0, "w_row0_after_write");

        tick();
        tick();
        tick();
        chk("queue_drained", 32'(exp_data_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gcn_matrix_memory.md
GCN_MATRIX_MEMORY -- requirements
Module: gcn_matrix_memory

Interface
REQ-001 Parameter FEATURE_ROWS, 6, number of feature-matrix rows (graph nodes).
REQ-002 Parameter FEATURE_COLS, 96, elements per feature row.
REQ-003 Parameter WEIGHT_COLS, 3, number of stored weight rows (transposed weight matrix).
REQ-004 Parameter WEIGHT_ROWS, 96, elements per weight row, and width of the read bus.
REQ-005 Parameter DATA_WIDTH, 5, bits per element.
REQ-006 Parameter ADDRESS_WIDTH, 13, read address width.
REQ-007 Parameter FEATURE_BASE, 512, first feature-row address.
REQ-008 clk  in  1  sole clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 load_start  in  1  one-cycle pulse that begins a matrix load.
REQ-011 load_sel  in  1  0 = weight matrix, 1 = feature matrix; sampled with load_start.
REQ-012 load_valid  in  1  load_data is valid this cycle.
REQ-013 load_data  in  DATA_WIDTH  next element, row-major.
REQ-014 load_ready  out  1  loader accepts an element this cycle.
REQ-015 load_done  out  1  one-cycle pulse after the last element is written.
REQ-016 enable_read  in  1  read request from the transformation engine.
REQ-017 read_address  in  ADDRESS_WIDTH  row address: 0..WEIGHT_COLS-1 weight, FEATURE_BASE..FEATURE_BASE+FEATURE_ROWS-1 feature.
REQ-018 data_out  out  WEIGHT_ROWS x DATA_WIDTH  unpacked row of elements.
REQ-019 data_valid  out  1  data_out carries the response to the previous cycle's request.
REQ-020 addr_error  out  1  previous cycle's request targeted an unmapped address.

Function
REQ-021 Loader FSM states are IDLE, LOAD, DONE; IDLE->LOAD on load_start; LOAD->DONE when the final element is accepted; DONE->IDLE unconditionally.
REQ-022 load_ready is 1 only in LOAD; an element is accepted when load_valid and load_ready are both 1.
REQ-023 Column counter wraps 95->0 and advances the row counter; load ends after WEIGHT_COLS*96 (weight) or FEATURE_ROWS*96 (feature) accepted elements.
REQ-024 load_done is asserted for exactly the DONE cycle.
REQ-025 load_start outside IDLE is ignored.
REQ-026 Read latency is exactly 1 cycle: a request at edge N drives data_out, data_valid=1 and addr_error after edge N+1.
REQ-027 Feature row index is read_address minus FEATURE_BASE; weight row index is read_address.
REQ-028 An unmapped address returns all-zero data_out, addr_error=1, data_valid=1.
REQ-029 With enable_read=0, data_out holds its last value and data_valid=0, addr_error=0.
REQ-030 Reads are served during a load; unwritten elements return their prior contents.
REQ-031 Same-cycle write and read of the same row follows REQ-036.

Reset
REQ-032 Reset forces loader to IDLE, counters to 0, load_ready=0, load_done=0, data_valid=0, addr_error=0, data_out all zero.
REQ-033 Reset mid-load aborts the load; elements already written are retained; storage is never cleared by reset.
REQ-034 Reset has priority over load_start and enable_read in the same cycle.

Configuration
REQ-035 Macro GCN_MEM_WR_BYPASS_EN selects same-cycle write forwarding.
REQ-036 Defined: a read of the row being written in the same cycle returns the new element; undefined: it returns the pre-write value.

Structure
REQ-037 Package gcn_mem_pkg holds the loader state enum, the FEATURE_BASE constant and the row typedef (WEIGHT_ROWS x DATA_WIDTH).
REQ-038 Sub-module gcn_mem_loader contains the loader FSM and counters and emits write enable, row and column.

Verification
REQ-039 Load weights 0..287 mod 32, read address 1 -> next cycle data_out[k]=(96+k) mod 32, data_valid=1, addr_error=0.
REQ-040 Load features with element=row index, read address 517 -> all elements 5; address 518 -> zeros, addr_error=1.
REQ-041 Drop load_valid every other cycle during a weight load -> load_done after exactly 288 accepted elements, single-cycle pulse.
REQ-042 Assert reset after 100 feature elements, then read 512 -> row 0 holds new values, row 1 elements 4..95 hold old values, loader IDLE.
REQ-043 Write element 0 of weight row 0 with 7 while reading address 0 -> data_out[0]=7 with GCN_MEM_WR_BYPASS_EN, old value without.
REQ-044 Pulse load_start during LOAD -> ignored, element count and load_done timing unchanged.
